// File: rtl/sumador_restador_serial.sv
// Multi-cycle two's-complement adder/subtractor that sums CHUNK bits per clock.
// Optional feature: define SUMADOR_SATURATE_EN to clamp the result on signed overflow.
module sumador_restador_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             inclk,
  input  logic             inrst_n,
  input  logic             instart,
  input  logic             insub,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             outbusy,
  output logic             outdone,
  output logic [WIDTH-1:0] outs,
  output logic             outcarry,
  output logic             outoverflow,
  output logic             outzero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0]    LAST_CHUNK = CW'(N - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});
  localparam logic [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             final_ovf;
  logic [WIDTH-1:0] next_result;
  logic [WIDTH-1:0] final_s;

  assign outbusy = (state == ST_RUN);

  // One ripple slice; the chunk is picked by shifting so the slice
  // position follows the counter without a wide mux tree per bit.
  // NOTE: every signal written here gets a value first, so no latch can be inferred.
  always_comb begin
    shamt       = 32'(cnt) * 32'(CHUNK);
    chunk_a     = CHUNK'(op_a >> shamt);
    chunk_b     = CHUNK'(op_b >> shamt);
    chunk_sum   = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    // Carry into the MSB recovered from the MSB sum bit of the top slice.
    msb_cin     = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
    final_ovf   = msb_cin ^ chunk_sum[CHUNK];
    next_result = (result & ~(CHUNK_MASK << shamt))
                | (WIDTH'(chunk_sum[CHUNK-1:0]) << shamt);
    final_s     = next_result;
`ifdef SUMADOR_SATURATE_EN
    if (final_ovf) begin
      final_s = op_a[WIDTH-1] ? MIN_NEG : MAX_POS;
    end
`else
    if (1'b0) begin
      final_s = MAX_POS & MIN_NEG;
    end
`endif
  end

  // Control state and the visible result registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge inclk) begin
    if (!inrst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      outdone     <= 1'b0;
      outs        <= '0;
      outcarry    <= 1'b0;
      outoverflow <= 1'b0;
      outzero     <= 1'b0;
    end else begin
      outdone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instart) begin
            state <= ST_RUN;
            cnt   <= '0;
            carry <= insub;
          end
        end
        ST_RUN: begin
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_CHUNK) begin
            state       <= ST_IDLE;
            outdone     <= 1'b1;
            outs        <= final_s;
            outcarry    <= chunk_sum[CHUNK];
            outoverflow <= final_ovf;
            outzero     <= (final_s == '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: operand and partial-result registers are not reset; they are always
  // loaded at start accept or written chunk by chunk before anything reads them.
  always_ff @(posedge inclk) begin
    if (state == ST_IDLE && instart) begin
      op_a <= ina;
      op_b <= insub ? ~inb : inb;
    end else if (state == ST_RUN) begin
      result <= next_result;
    end
  end

endmodule
